// File: rtl/mdu_iter_if.sv
// mdu_iter request/result bundle: start/op/operands in, busy/done/HI/LO out.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/DIV unit with HI/LO registers, one bit per cycle.
// Define MDU_MADD_EN to build MADD/MADDU accumulation into HI/LO.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] dvs;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             div_zero;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
`ifdef MDU_MADD_EN
  logic             is_acc;
  logic             go_acc;
`endif

  logic             go_mul;
  logic             go_div;
  logic             is_mthi;
  logic             is_mtlo;
  logic             op_signed;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    go_mul  = 1'b0;
    go_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
`ifdef MDU_MADD_EN
    go_acc  = 1'b0;
`endif
    unique case (bus.op)
      3'b000, 3'b001: go_mul  = 1'b1;
      3'b010, 3'b011: go_div  = 1'b1;
      3'b100:         is_mthi = 1'b1;
      3'b101:         is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
      3'b110, 3'b111: begin
        go_mul = 1'b1;
        go_acc = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Even opcodes of each pair are the signed variants
  assign op_signed = ~bus.op[0];
  assign sa        = op_signed & bus.A[WIDTH-1];
  assign sb        = op_signed & bus.B[WIDTH-1];
  assign mag_a     = sa ? -bus.A : bus.A;
  assign mag_b     = sb ? -bus.B : bus.B;

  assign mul_sum  = {1'b0, acc_hi}
                  + (acc_lo[0] ? {1'b0, dvs} : '0);
  assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, dvs};

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_lo ? -prod : prod;
  assign q_fix    = div_zero ? '1
                  : (neg_lo ? -acc_lo : acc_lo);
  assign r_fix    = neg_hi ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      dvs      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_MADD_EN
      is_acc   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              go_mul | go_div: begin
                state    <= CALC;
                busy_q   <= 1'b1;
                cnt      <= '0;
                acc_hi   <= '0;
                acc_lo   <= go_div ? mag_a : mag_b;
                dvs      <= go_div ? mag_b : mag_a;
                is_div   <= go_div;
                neg_lo   <= sa ^ sb;
                neg_hi   <= sa;
                div_zero <= go_div & (bus.B == '0);
`ifdef MDU_MADD_EN
                is_acc   <= go_acc;
`endif
              end
              is_mthi: hi_q <= bus.A;
              is_mtlo: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.cancel) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (is_div) begin
              if (!div_diff[WIDTH]) begin
                acc_hi <= div_diff[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
              end else begin
                acc_hi <= div_sh[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!bus.cancel) begin
            done_q <= 1'b1;
`ifdef MDU_MADD_EN
            if (is_acc)
              {hi_q, lo_q} <= {hi_q, lo_q} + prod_fix;
            else
`endif
            if (is_div) begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: arithmetic reference model with a
// countdown timing model, compared every cycle, plus literal checks.
module tb_mdu_iter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_on = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   bc;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0]   m_hi   = '0;
  logic [W-1:0]   m_lo   = '0;
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_res  = '0;

  function automatic bit md_op(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return (o <= 3'd3) || (o >= 3'd6);
`else
    return o <= 3'd3;
`endif
  endfunction

  function automatic logic [2*W-1:0] calc(
    input logic [2:0]     o,
    input logic [W-1:0]   a,
    input logic [W-1:0]   b,
    input logic [2*W-1:0] cur
  );
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0]        up;
    logic signed [W-1:0]   sa, sb, q, r;
    sa = a;
    sb = b;
    sp = 64'(sa) * 64'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return sp;
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd6: return cur + sp;
      3'd7: return cur + up;
      default: return cur;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (bus.cancel) begin
          m_left <= 0;
          m_busy <= 1'b0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_res[2*W-1:W];
            m_lo   <= m_res[W-1:0];
            m_done <= 1'b1;
            m_busy <= 1'b0;
          end
        end
      end else if (bus.start) begin
        if (md_op(bus.op)) begin
          m_res  <= calc(bus.op, bus.A, bus.B, {m_hi, m_lo});
          m_left <= LAT;
          m_busy <= 1'b1;
        end else if (bus.op == 3'd4) begin
          m_hi <= bus.A;
        end else if (bus.op == 3'd5) begin
          m_lo <= bus.A;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_busy", bus.busy, m_busy);
      check("m_done", bus.done, m_done);
      check("m_hi", bus.hi, m_hi);
      check("m_lo", bus.lo, m_lo);
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) bc++;
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.done, 1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bc = 0;
    wait_done();
  endtask

  task automatic mt(input logic [2:0] o, input logic [W-1:0] a);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    @(negedge clk);
    bus.start = 1'b0;
    check("mt_busy", bus.busy, 0);
    if (o == 3'd4) check("mthi", bus.hi, a);
    else           check("mtlo", bus.lo, a);
  endtask

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t vt[6] = '{
    '{3'd0, 32'h8000_0000, 32'h8000_0000},
    '{3'd2, 32'hFFFF_FF9C, 32'd7},
    '{3'd2, 32'd100, 32'hFFFF_FFF9},
    '{3'd3, 32'hFFFF_FFFF, 32'd1},
    '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd2, 32'h8000_0000, 32'd0}
  };

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.A      = '0;
    bus.B      = '0;
    bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy_cyc", bc, LAT);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFF1);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    check("multu_hi", bus.hi, 32'h0000_0004);
    check("multu_lo", bus.lo, 32'hFFFF_FFF1);
    run_op(3'd3, 32'd100, 32'd7);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lo", bus.lo, 32'h8000_0000);
    check("ovf_hi", bus.hi, 32'd0);
    run_op(3'd2, 32'h0000_1234, 32'd0);
    check("dz_busy_cyc", bc, LAT);
    check("dz_lo", bus.lo, 32'hFFFF_FFFF);
    check("dz_hi", bus.hi, 32'h0000_1234);

    @(negedge clk);
    mt(3'd4, 32'hAAAA_5555);
    mt(3'd5, 32'h0000_0001);

    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.A     = 32'd7;
    bus.B     = 32'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.A     = 32'd100;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    bc = 0;
    wait_done();
    check("ign_lo", bus.lo, 32'd42);
    check("ign_hi", bus.hi, 32'd0);
    repeat (5) @(negedge clk);

    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    check("cancel_hi", bus.hi, 32'd0);
    check("cancel_lo", bus.lo, 32'd42);

    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = 3'd1;
    bus.A      = 32'd3;
    bus.B      = 32'd3;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bc = 0;
    wait_done();
    check("startwin_lo", bus.lo, 32'd9);

    foreach (vt[i]) run_op(vt[i].o, vt[i].a, vt[i].b);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.A     = 32'd50;
    bus.B     = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mt(3'd4, 32'd0);
    mt(3'd5, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op(3'd7, 32'd1, 32'd1);
    check("maddu_hi", bus.hi, 32'd1);
    check("maddu_lo", bus.lo, 32'd0);
`else
    bus.start = 1'b1;
    bus.op    = 3'd7;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("nomadd_busy", bus.busy, 0);
    repeat (40) @(negedge clk);
    check("nomadd_hi", bus.hi, 32'd0);
    check("nomadd_lo", bus.lo, 32'hFFFF_FFFF);
`endif
    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers.
- Sits beside the combinational ALU in the execute stage. Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO for the multi-cycle datapath.
- Uses a start/busy/done handshake. The control unit stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled on rising clk edge; ignored while busy=1.
- op  input  3  operation code, sampled with start.
- A  input  WIDTH  operand rs (dividend/multiplicand/MTHI-MTLO source).
- B  input  WIDTH  operand rt (divisor/multiplier).
- cancel  input  1  abort in-flight op; HI/LO unchanged.
- busy  output  1  registered; high while iterating.
- done  output  1  registered one-cycle pulse when HI/LO updated by mult/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Opcodes:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU.
  - 100 MTHI, 101 MTLO.
  - 110 MADD, 111 MADDU (Optional Feature only; otherwise a no-op, start ignored).
- Reset (rst_n=0, async): hi=0, lo=0, busy=0, done=0, FSM=IDLE, iteration counter=0, internal shift registers cleared. Reset mid-operation aborts it with no HI/LO write.
- FSM states: IDLE, CALC, FIX.
  - IDLE: start with a mult/div op goes to CALC at the edge. The edge latches operand magnitudes and sign flags, counter=0, busy=1.
  - IDLE: start with MTHI or MTLO writes hi<=A or lo<=A at that edge. Stays IDLE, busy stays 0, done stays 0.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter increments; at counter=WIDTH-1 goes to FIX.
  - FIX: applies sign correction; writes hi/lo; done=1 for exactly this edge's following cycle; busy=0; back to IDLE.
- Latency: start accepted at edge 0. Result is visible on hi/lo and done=1 after edge WIDTH+1 (33 cycles for WIDTH=32). busy is high from after edge 0 until edge WIDTH+1.
- Back-to-back: start may be asserted in the cycle done=1 and is accepted.
- start while busy: ignored, no queueing.
- cancel: has priority over CALC/FIX progress. Any busy state goes to IDLE next edge: busy=0, done=0, hi/lo untouched. cancel in IDLE has no effect. Simultaneous cancel and start in IDLE: start wins.
- Multiply:
  - 2*WIDTH product, {hi,lo}=product.
  - MULT: operands converted to magnitudes, product negated (two's complement, 2*WIDTH bits) if sign(A)^sign(B).
  - MULTU: no conversion.
- Divide:
  - lo=quotient, hi=remainder.
  - DIV: quotient sign = sign(A)^sign(B); remainder sign = sign(A) (truncation toward zero).
  - DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1) (wraps), hi=0.
  - Divide by zero (B=0), both DIV and DIVU: still takes full latency; lo=all ones, hi=A.
- hi/lo change only on reset, MTHI/MTLO, or FIX. Nothing else writes them.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 110 MADD and 111 MADDU accumulate, {hi,lo} <= {hi,lo} + product, with signed/unsigned product as MULT/MULTU. Accumulation is in the FIX cycle, modulo 2^(2*WIDTH), same latency as MULT.
- Undefined: ops 110/111 are ignored (no state change, busy stays 0) and the accumulator adder is not built.

Test Plan:
- Reset then MULT A=0xFFFFFFFD (-3), B=5 -> busy high 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU A=100, B=7 -> lo=14, hi=2. DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV A=0x1234, B=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00001234, done=1.
- MTHI A=0xAAAA5555 then MTLO A=0x1 -> hi/lo update the next edge; busy never rises. Start MULT, assert start with DIV at cycle 10 -> second request ignored, MULT result only.
- Start DIVU, assert cancel at cycle 5 -> busy=0 next cycle, no done, hi/lo keep prior values. Repeat with rst_n low at cycle 12 -> all outputs 0 immediately (async).
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU A=1, B=1 -> hi=1, lo=0. Without the macro the same op -> busy stays 0, hi/lo unchanged.
